qsys_avm_arbiter: RTL

Two-port Avalon-MM arbiter that shares a single Avalon master (the fabric path used by the SAM9 host bridge) between two requesters: host-bridge traffic on port S0 and a local requester (DMA/sequencer) on port S1. It registers the winning command onto the master port and holds the grant until the transfer completes. For reads, completion is when `readdatavalid` returns. Only one transfer is outstanding at a time, and a read-latency watchdog guarantees a requester is never hung.

---
 rtl/qsys_avm_arbiter_if.sv | 31 +++
 rtl/qsys_avm_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/qsys_avm_arbiter_if.sv
`timescale 1ns/1ps
// qsys_avm_arbiter_if
// Avalon-MM bus bundle used on every arbiter port.
//   master modport : drives command (address, writedata, byteenable, read,
//                    write, begintransfer), receives readdata,
//                    readdatavalid, waitrequest.
//   slave modport  : the mirror image of master.
interface qsys_avm_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   address;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic                begintransfer;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, writedata, byteenable, read, write, begintransfer,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, writedata, byteenable, read, write, begintransfer,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/qsys_avm_arbiter.sv
`timescale 1ns/1ps
// qsys_avm_arbiter
// Shares one Avalon-MM master (M1) between two requesters: S0 (host bridge)
// and S1 (local DMA/sequencer). Round-robin on ties, one transfer in flight,
// winning command registered onto M1. Reads complete on readdatavalid or,
// after TIMEOUT cycles in RDWAIT, with a synthetic all-ones completion.
// Ports:
//   csi_MCLK_clk       clock
//   rsi_MRST_reset_n   asynchronous active-low reset
//   avs_S0, avs_S1     requester ports (slave side of the bus bundle)
//   avm_M1             shared master port
//   coe_ARB_TIMEOUT    one-cycle pulse when the read watchdog fires
//   coe_ARB_GRANT      index of the current or last grant
module qsys_avm_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               csi_MCLK_clk,
  input  logic               rsi_MRST_reset_n,
  qsys_avm_arbiter_if.slave  avs_S0,
  qsys_avm_arbiter_if.slave  avs_S1,
  qsys_avm_arbiter_if.master avm_M1,
  output logic               coe_ARB_TIMEOUT,
  output logic               coe_ARB_GRANT
);

  localparam int BE_W = DATA_W / 8;
  // Watchdog is cleared on RDWAIT entry, so leaving at count TIMEOUT-1 puts
  // TOUT exactly TIMEOUT+1 cycles after command acceptance.
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, CMD, RDWAIT, TOUT} state_t;

  state_t            state_q, state_d;
  logic              grant_q, last_q;
  logic [15:0]       wdog_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              read_q, write_q, begin_q;

  logic              req0, req1, any_req, winner;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [BE_W-1:0]   win_be;
  logic              win_read, win_write;
  logic              unused_begintransfer;

  assign unused_begintransfer = avs_S0.begintransfer ^ avs_S1.begintransfer;

  // Winner selection: a lone requester wins; on a tie the port that did not
  // win last time goes. Read+write on one port is treated as a read.
  always_comb begin
    req0    = avs_S0.read | avs_S0.write;
    req1    = avs_S1.read | avs_S1.write;
    any_req = req0 | req1;
    winner  = 1'b0;
    if (req0 && req1) winner = ~last_q;
    else if (req1)    winner = 1'b1;
    win_addr  = winner ? avs_S1.address    : avs_S0.address;
    win_wdata = winner ? avs_S1.writedata  : avs_S0.writedata;
    win_be    = winner ? avs_S1.byteenable : avs_S0.byteenable;
    win_read  = winner ? avs_S1.read       : avs_S0.read;
    win_write = ~win_read & (winner ? avs_S1.write : avs_S0.write);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = CMD;
      CMD:     if (!avm_M1.waitrequest) state_d = read_q ? RDWAIT : IDLE;
      RDWAIT: begin
        if (avm_M1.readdatavalid)    state_d = IDLE;
        else if (wdog_q == WDOG_LAST) state_d = TOUT;
      end
      TOUT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      wdog_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      begin_q <= 1'b0;
    end else begin
      state_q <= state_d;
      begin_q <= 1'b0;
      wdog_q  <= (state_q == RDWAIT) ? wdog_q + 16'd1 : '0;
      if (state_q == IDLE && any_req) begin
        addr_q  <= win_addr;
        wdata_q <= win_wdata;
        be_q    <= win_be;
        read_q  <= win_read;
        write_q <= win_write;
        begin_q <= 1'b1;
        grant_q <= winner;
        last_q  <= winner;
      end
      if (state_q == CMD && !avm_M1.waitrequest) begin
        read_q  <= 1'b0;
        write_q <= 1'b0;
      end
    end
  end

  assign avm_M1.address       = addr_q;
  assign avm_M1.writedata     = wdata_q;
  assign avm_M1.byteenable    = be_q;
  assign avm_M1.read          = read_q;
  assign avm_M1.write         = write_q;
  assign avm_M1.begintransfer = begin_q;

  assign avs_S0.waitrequest = ~(state_q == CMD && !grant_q && !avm_M1.waitrequest);
  assign avs_S1.waitrequest = ~(state_q == CMD &&  grant_q && !avm_M1.waitrequest);

  assign avs_S0.readdata = (state_q == TOUT) ? '1 : avm_M1.readdata;
  assign avs_S1.readdata = (state_q == TOUT) ? '1 : avm_M1.readdata;

  // Late readdatavalid outside RDWAIT is dropped here.
  assign avs_S0.readdatavalid = !grant_q &&
    ((state_q == RDWAIT && avm_M1.readdatavalid) || state_q == TOUT);
  assign avs_S1.readdatavalid =  grant_q &&
    ((state_q == RDWAIT && avm_M1.readdatavalid) || state_q == TOUT);

  assign coe_ARB_TIMEOUT = (state_q == TOUT);
  assign coe_ARB_GRANT   = grant_q;

endmodule
